// File: rtl/threefish_stream_loader.sv
// Threefish-512 stream loader.
// Gathers key, tweak and plaintext words from a narrow valid/ready stream.
// Strobes them into the block core, waits out the core's busy period,
// then streams the 512-bit result back out word by word.
module threefish_stream_loader #(
  parameter int DATA_W       = 32,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              inClk,
  input  logic              inRstN,
  input  logic [DATA_W-1:0] inData,
  input  logic              inValid,
  input  logic              inReuseKey,
  output logic              outReady,
  output logic [511:0]      outKey,
  output logic              outKeyWr,
  output logic [127:0]      outTweak,
  output logic              outTweakWr,
  output logic [511:0]      outBlock,
  output logic              outBlockWr,
  input  logic [511:0]      inCoreBlock,
  input  logic              inCoreBusy,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              inReady,
  output logic              outIdle,
  output logic              outError
);

  localparam int NK = 512 / DATA_W;
  localparam int NB = 512 / DATA_W;
  localparam int NT = 128 / DATA_W;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_KEY,
    LOAD_TWEAK,
    LOAD_BLOCK,
    WR_KEY,
    WR_TWEAK,
    WR_BLOCK,
    WAIT_HI,
    WAIT_LO,
    CAPTURE,
    UNLOAD
  } loaderState;

  loaderState   state;
  loaderState   nextState;
  logic [4:0]   wordCnt;
  logic [4:0]   loadIdx;
  logic [8:0]   bitBase;
  logic [7:0]   timeoutCnt;
  logic [511:0] keyReg;
  logic [127:0] tweakReg;
  logic [511:0] blockReg;
  logic [511:0] outShift;
  logic         keyValid;
  logic         errorReg;
  logic         reuseFrame;
  logic         inXfer;
  logic         outXfer;
  logic         loadLast;
  logic         busyTimeout;
  logic         firstWord;
  logic         reuseGranted;

  // Handshake qualifiers: input is accepted only while loading, output only while unloading.
  assign outReady = (state == IDLE) || (state == LOAD_KEY) ||
                    (state == LOAD_TWEAK) || (state == LOAD_BLOCK);
  assign outValid = (state == UNLOAD);
  assign outIdle  = (state == IDLE);
  assign inXfer   = inValid & outReady;
  assign outXfer  = outValid & inReady;

  // The first word of a frame is consumed in IDLE, so the key and reuse-block
  // loads start one word further in; the counter itself always restarts at 0.
  assign firstWord    = (state == IDLE) && inXfer;
  assign reuseGranted = inReuseKey & keyValid;
  assign loadIdx      = wordCnt + (((state == LOAD_KEY) ||
                                    ((state == LOAD_BLOCK) && reuseFrame)) ? 5'd1 : 5'd0);
  assign bitBase      = 9'(loadIdx) * 9'(DATA_W);
  assign busyTimeout  = (state == WAIT_HI) && !inCoreBusy &&
                        (timeoutCnt == 8'(BUSY_TIMEOUT - 1));

  assign outKey   = keyReg;
  assign outTweak = tweakReg;
  assign outBlock = blockReg;
  assign outData  = outShift[DATA_W-1:0];
  assign outError = errorReg;

  // Detect the last word of whichever load phase is active.
  always_comb begin
    loadLast = 1'b0;
    case (state)
      LOAD_KEY:   loadLast = (loadIdx == 5'(NK - 1));
      LOAD_TWEAK: loadLast = (loadIdx == 5'(NT - 1));
      LOAD_BLOCK: loadLast = (loadIdx == 5'(NB - 1));
      default:    loadLast = 1'b0;
    endcase
  end

  // State register; reset drops straight back to IDLE from anywhere.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode and the one-cycle core write strobes.
  always_comb begin
    nextState  = state;
    outKeyWr   = 1'b0;
    outTweakWr = 1'b0;
    outBlockWr = 1'b0;
    case (state)
      IDLE: begin
        if (inXfer) begin
          nextState = reuseGranted ? LOAD_BLOCK : LOAD_KEY;
        end
      end
      LOAD_KEY: begin
        if (inXfer && loadLast) begin
          nextState = LOAD_TWEAK;
        end
      end
      LOAD_TWEAK: begin
        if (inXfer && loadLast) begin
          nextState = LOAD_BLOCK;
        end
      end
      LOAD_BLOCK: begin
        if (inXfer && loadLast) begin
          nextState = reuseFrame ? WR_BLOCK : WR_KEY;
        end
      end
      WR_KEY: begin
        outKeyWr  = 1'b1;
        nextState = WR_TWEAK;
      end
      WR_TWEAK: begin
        outTweakWr = 1'b1;
        nextState  = WR_BLOCK;
      end
      WR_BLOCK: begin
        outBlockWr = 1'b1;
        nextState  = WAIT_HI;
      end
      WAIT_HI: begin
        if (inCoreBusy) begin
          nextState = WAIT_LO;
        end else if (busyTimeout) begin
          nextState = IDLE;
        end
      end
      WAIT_LO: begin
        if (!inCoreBusy) begin
          nextState = CAPTURE;
        end
      end
      CAPTURE: begin
        nextState = UNLOAD;
      end
      UNLOAD: begin
        if (outXfer && (wordCnt == 5'(NB - 1))) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Word counter: restarts on every state change, steps on each accepted or delivered word.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      wordCnt <= 5'd0;
    end else if (state != nextState) begin
      wordCnt <= 5'd0;
    end else if (inXfer || outXfer) begin
      wordCnt <= wordCnt + 5'd1;
    end
  end

  // Busy-rise watchdog, armed when the block strobe goes out.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      timeoutCnt <= 8'd0;
    end else if (state == WR_BLOCK) begin
      timeoutCnt <= 8'd0;
    end else if (state == WAIT_HI) begin
      timeoutCnt <= timeoutCnt + 8'd1;
    end
  end

  // Key, tweak and block registers only move while words are being accepted,
  // so the core sees them frozen for the whole run.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      keyReg   <= '0;
      tweakReg <= '0;
      blockReg <= '0;
    end else if (inXfer) begin
      case (state)
        IDLE: begin
          if (reuseGranted) begin
            blockReg[DATA_W-1:0] <= inData;
          end else begin
            keyReg[DATA_W-1:0] <= inData;
          end
        end
        LOAD_KEY:   keyReg[bitBase +: DATA_W] <= inData;
        LOAD_TWEAK: tweakReg[bitBase[6:0] +: DATA_W] <= inData;
        LOAD_BLOCK: blockReg[bitBase +: DATA_W] <= inData;
        default: ;
      endcase
    end
  end

  // Frame bookkeeping: key-loaded flag, frame type and the sticky error.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      keyValid   <= 1'b0;
      reuseFrame <= 1'b0;
      errorReg   <= 1'b0;
    end else begin
      if (state == WR_KEY) begin
        keyValid <= 1'b1;
      end
      if (firstWord) begin
        reuseFrame <= reuseGranted;
        errorReg   <= inReuseKey & ~keyValid;
      end else if (busyTimeout) begin
        errorReg <= 1'b1;
      end
    end
  end

  // Result shift register: captured after busy falls, drained LSW first.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      outShift <= '0;
    end else if (state == CAPTURE) begin
      outShift <= inCoreBlock;
    end else if (outXfer) begin
      outShift <= outShift >> DATA_W;
    end
  end

endmodule

// File: tb/tb_threefish_stream_loader.sv
// Testbench for threefish_stream_loader: directed frames against a simple
// frame-level model with a behavioural Threefish core stand-in.
module tb_threefish_stream_loader;

  localparam int DW = 32;
  localparam int NK = 16;
  localparam int NT = 4;
  localparam int NB = 16;

  logic          inClk = 1'b0;
  logic          inRstN;
  logic [DW-1:0] inData;
  logic          inValid;
  logic          inReuseKey;
  logic          outReady;
  logic [511:0]  outKey;
  logic          outKeyWr;
  logic [127:0]  outTweak;
  logic          outTweakWr;
  logic [511:0]  outBlock;
  logic          outBlockWr;
  logic [511:0]  inCoreBlock;
  logic          inCoreBusy;
  logic [DW-1:0] outData;
  logic          outValid;
  logic          inReady;
  logic          outIdle;
  logic          outError;

  int checks = 0;
  int passes = 0;

  logic [511:0] expKey;
  logic [127:0] expTweak;
  logic [511:0] expBlock;
  bit           expKeyValid;
  bit           expFull;
  logic [DW-1:0] expOutQ[$];

  bit           coreRespond;
  int           coreBusyCycles;
  logic [511:0] coreResult;

  int keyWrCnt = 0;
  int tweakWrCnt = 0;
  int blockWrCnt = 0;
  int outXferCnt = 0;
  int outValidCnt = 0;
  bit prevKeyWr = 1'b0;
  bit prevTweakWr = 1'b0;

  always #5 inClk = ~inClk;

  threefish_stream_loader #(.DATA_W(DW), .BUSY_TIMEOUT(16)) dut (
    .inClk(inClk), .inRstN(inRstN), .inData(inData), .inValid(inValid),
    .inReuseKey(inReuseKey), .outReady(outReady), .outKey(outKey),
    .outKeyWr(outKeyWr), .outTweak(outTweak), .outTweakWr(outTweakWr),
    .outBlock(outBlock), .outBlockWr(outBlockWr), .inCoreBlock(inCoreBlock),
    .inCoreBusy(inCoreBusy), .outData(outData), .outValid(outValid),
    .inReady(inReady), .outIdle(outIdle), .outError(outError)
  );

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand one word to the loader and wait (bounded) for it to be accepted.
  task automatic pushWord(input logic [DW-1:0] w, input logic reuse);
    int guard = 0;
    inData = w;
    inValid = 1'b1;
    inReuseKey = reuse;
    @(negedge inClk);
    while (!outReady && guard < 200) begin
      @(negedge inClk);
      guard++;
    end
    if (!outReady) begin
      checkOutput("pushWordAccepted", outReady, 1);
    end
    @(posedge inClk);
    #1;
    inValid = 1'b0;
    inReuseKey = 1'b0;
  endtask

  // Send one frame; the model decides full versus reuse from what it knows.
  task automatic applyStimulus(input logic [DW-1:0] keyBase, input logic [DW-1:0] tweakBase,
                               input logic [DW-1:0] blockBase, input logic reuse);
    expFull = !(reuse && expKeyValid);
    if (expFull) begin
      for (int i = 0; i < NK; i++) begin
        expKey[i*DW +: DW] = keyBase + DW'(i);
        pushWord(keyBase + DW'(i), (i == 0) ? reuse : 1'b0);
      end
      for (int i = 0; i < NT; i++) begin
        expTweak[i*DW +: DW] = tweakBase + DW'(i);
        pushWord(tweakBase + DW'(i), 1'b0);
      end
    end
    for (int i = 0; i < NB; i++) begin
      expBlock[i*DW +: DW] = blockBase + DW'(i);
      pushWord(blockBase + DW'(i), (i == 0 && !expFull) ? reuse : 1'b0);
    end
    if (expFull) begin
      expKeyValid = 1'b1;
    end
  endtask

  task automatic resetDut();
    inRstN = 1'b0;
    inValid = 1'b0;
    inReuseKey = 1'b0;
    inReady = 1'b1;
    expKey = '0;
    expTweak = '0;
    expBlock = '0;
    expKeyValid = 1'b0;
    expOutQ.delete();
    repeat (2) @(negedge inClk);
    inRstN = 1'b1;
    @(posedge inClk);
    #1;
    checkOutput("noStrobeAfterReset", {outKeyWr, outTweakWr, outBlockWr}, 0);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (!(outIdle && expOutQ.size() == 0) && n < 1000) begin
      @(posedge inClk);
      #1;
      n++;
    end
    checkOutput(name, outIdle, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_outReady"}, outReady, 1);
    checkOutput({tag, "_outIdle"}, outIdle, 1);
    checkOutput({tag, "_outValid"}, outValid, 0);
    checkOutput({tag, "_outError"}, outError, 0);
    checkOutput({tag, "_strobes"}, {outKeyWr, outTweakWr, outBlockWr}, 0);
    checkOutput({tag, "_outKey"}, outKey, 0);
    checkOutput({tag, "_outTweak"}, outTweak, 0);
    checkOutput({tag, "_outBlock"}, outBlock, 0);
    checkOutput({tag, "_outData"}, outData, 0);
  endtask

  // Behavioural core: after a block write, busy for coreBusyCycles, then present the result.
  initial begin
    inCoreBusy = 1'b0;
    inCoreBlock = '0;
    forever begin
      @(negedge inClk);
      if (inRstN && outBlockWr && coreRespond) begin
        @(posedge inClk);
        #1;
        inCoreBusy = 1'b1;
        inCoreBlock = '0;
        repeat (coreBusyCycles) @(posedge inClk);
        #1;
        inCoreBlock = coreResult;
        inCoreBusy = 1'b0;
        for (int i = 0; i < NB; i++) begin
          expOutQ.push_back(coreResult[i*DW +: DW]);
        end
      end
    end
  end

  // Compare process: strobes against the model registers, output words against the queue.
  initial begin
    forever begin
      @(negedge inClk);
      if (!inRstN) begin
        expOutQ.delete();
        prevKeyWr = 1'b0;
        prevTweakWr = 1'b0;
      end else begin
        if (outKeyWr) begin
          keyWrCnt++;
          checkOutput("keyAtKeyWr", outKey, expKey);
        end
        if (outTweakWr) begin
          tweakWrCnt++;
          checkOutput("tweakAtTweakWr", outTweak, expTweak);
          checkOutput("keyWrJustBeforeTweakWr", prevKeyWr, 1);
        end
        if (outBlockWr) begin
          blockWrCnt++;
          checkOutput("blockAtBlockWr", outBlock, expBlock);
          checkOutput("keyAtBlockWr", outKey, expKey);
          checkOutput("tweakAtBlockWr", outTweak, expTweak);
          checkOutput("tweakWrJustBeforeBlockWr", prevTweakWr, expFull);
        end
        prevKeyWr = outKeyWr;
        prevTweakWr = outTweakWr;
        if (outValid) begin
          outValidCnt++;
          if (expOutQ.size() == 0) begin
            checkOutput("outValidWithoutResult", outValid, 0);
          end else begin
            checkOutput("outData", outData, expOutQ[0]);
            if (inReady) begin
              void'(expOutQ.pop_front());
              outXferCnt++;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kw, tw, bw, xf, vc, cycles, k;
    inRstN = 1'b0;
    inData = '0;
    inValid = 1'b0;
    inReuseKey = 1'b0;
    inReady = 1'b1;
    coreRespond = 1'b1;
    coreBusyCycles = 40;
    coreResult = '0;
    expFull = 1'b1;
    #12;
    checkResetOutputs("reset");
    resetDut();

    $display("[TB] full frame, result A5");
    coreResult = {16{32'hA5A5A5A5}};
    kw = keyWrCnt; tw = tweakWrCnt; bw = blockWrCnt; xf = outXferCnt;
    applyStimulus(32'h00, 32'h10, 32'h20, 1'b0);
    waitIdle("fullFrameIdle");
    checkOutput("fullKeyLsw", outKey[31:0], 32'h00);
    checkOutput("fullKeyMsw", outKey[511:480], 32'h0F);
    checkOutput("fullTweakMsw", outTweak[127:96], 32'h13);
    checkOutput("fullBlockLsw", outBlock[31:0], 32'h20);
    checkOutput("fullBlockMsw", outBlock[511:480], 32'h2F);
    checkOutput("fullWordsOut", outXferCnt - xf, 16);
    checkOutput("fullStrobes", {keyWrCnt - kw, tweakWrCnt - tw, blockWrCnt - bw}, {32'd1, 32'd1, 32'd1});
    checkOutput("fullError", outError, 0);

    $display("[TB] reuse frame with stalled downstream");
    for (int i = 0; i < NB; i++) coreResult[i*DW +: DW] = 32'hB000_0000 + DW'(i * 17);
    kw = keyWrCnt; tw = tweakWrCnt; bw = blockWrCnt; xf = outXferCnt;
    applyStimulus(32'h00, 32'h00, 32'h40, 1'b1);
    checkOutput("reuseStopsAfter16", outReady, 0);
    k = 0;
    while (!(outIdle && expOutQ.size() == 0) && k < 1000) begin
      @(posedge inClk);
      #1;
      inReady = ((k % 4) == 0) || ((k % 4) == 3);
      k++;
    end
    inReady = 1'b1;
    checkOutput("reuseIdle", outIdle, 1);
    checkOutput("reuseWordsOut", outXferCnt - xf, 16);
    checkOutput("reuseStrobes", {keyWrCnt - kw, tweakWrCnt - tw, blockWrCnt - bw}, {32'd0, 32'd0, 32'd1});
    checkOutput("reuseKeyKept", outKey[31:0], 32'h00);
    checkOutput("reuseTweakKept", outTweak[127:96], 32'h13);
    checkOutput("reuseBlockMsw", outBlock[511:480], 32'h4F);

    $display("[TB] core never goes busy");
    coreRespond = 1'b0;
    bw = blockWrCnt; vc = outValidCnt;
    applyStimulus(32'h00, 32'h00, 32'h60, 1'b1);
    cycles = 0;
    while (!outIdle && cycles < 100) begin
      @(posedge inClk);
      #1;
      cycles++;
    end
    checkOutput("timeoutCycles", cycles, 17);
    checkOutput("timeoutError", outError, 1);
    checkOutput("timeoutNoOutput", outValidCnt - vc, 0);
    checkOutput("timeoutBlockWr", blockWrCnt - bw, 1);
    coreRespond = 1'b1;

    $display("[TB] next frame clears the error");
    for (int i = 0; i < NB; i++) coreResult[i*DW +: DW] = 32'hC0DE_0000 ^ DW'(i << 8);
    applyStimulus(32'h00, 32'h00, 32'h70, 1'b1);
    checkOutput("errorCleared", outError, 0);
    waitIdle("clearIdle");

    $display("[TB] reset during tweak load");
    for (int i = 0; i < NK; i++) pushWord(32'h5500 + DW'(i), 1'b0);
    pushWord(32'h6600, 1'b0);
    pushWord(32'h6601, 1'b0);
    #3;
    inRstN = 1'b0;
    #1;
    checkResetOutputs("midTweakReset");
    resetDut();

    $display("[TB] reuse requested with no key loaded");
    for (int i = 0; i < NB; i++) coreResult[i*DW +: DW] = 32'h1234_0000 + DW'(i);
    kw = keyWrCnt;
    applyStimulus(32'h80, 32'h90, 32'hA0, 1'b1);
    checkOutput("noKeyError", outError, 1);
    checkOutput("noKeyConsumed36", outReady, 0);
    waitIdle("noKeyIdle");
    checkOutput("noKeyKeyWr", keyWrCnt - kw, 1);
    checkOutput("noKeyKeyLsw", outKey[31:0], 32'h80);

    $display("[TB] reset during unload");
    applyStimulus(32'h100, 32'h200, 32'h300, 1'b0);
    k = 0;
    while (!outValid && k < 400) begin
      @(negedge inClk);
      k++;
    end
    checkOutput("unloadStarted", outValid, 1);
    repeat (2) @(posedge inClk);
    #2;
    inRstN = 1'b0;
    #1;
    checkResetOutputs("unloadReset");
    resetDut();
    applyStimulus(32'h400, 32'h500, 32'h600, 1'b1);
    checkOutput("keyValidClearedByReset", outError, 1);
    waitIdle("finalIdle");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/threefish_stream_loader.md
Name: threefish_stream_loader

Overview:
- Upstream/downstream wrapper for the Threefish-512 block core.
- Assembles key, tweak and plaintext from a narrow valid/ready word stream and issues one-cycle key, tweak and block write strobes to the core.
- Waits for the core's busy cycle to complete, captures the 512-bit result and streams it back out on a valid/ready word interface.
- Holds key and tweak stable on the core inputs for the whole run, as the core reads them continuously while computing.

Parameters:
- DATA_W, 32: stream word width; must divide 128; legal values 32 or 64.
- BUSY_TIMEOUT, 16: maximum cycles to wait for core busy to rise after a block write; range 2..255.

Ports:
- inClk  in  1  clock; all state updates on rising edge.
- inRstN  in  1  asynchronous, active-low reset.
- inData  in  DATA_W  input stream word.
- inValid  in  1  inData valid.
- inReuseKey  in  1  sampled with the first word of a frame: frame carries block only, previous key and tweak are reused.
- outReady  out  1  loader accepts an input word this cycle.
- outKey  out  512  key to core.
- outKeyWr  out  1  one-cycle key write strobe.
- outTweak  out  128  tweak to core.
- outTweakWr  out  1  one-cycle tweak write strobe.
- outBlock  out  512  plaintext to core.
- outBlockWr  out  1  one-cycle block write strobe.
- inCoreBlock  in  512  core result.
- inCoreBusy  in  1  core busy flag.
- outData  out  DATA_W  result stream word.
- outValid  out  1  outData valid.
- inReady  in  1  downstream accepts outData.
- outIdle  out  1  high in IDLE.
- outError  out  1  sticky error flag; cleared by the next accepted first word.

Behaviour:
- Reset: all outputs 0, except outReady = 1 and outIdle = 1. Key, tweak and block registers = 0. keyValid flag = 0. State = IDLE.
- Reset mid-operation aborts immediately. No strobe may be issued in the cycle after reset deassertion.
- Word counts: NK = NB = 512/DATA_W, NT = 128/DATA_W.
- Word packing: word i occupies bits [i*DATA_W +: DATA_W]. Word 0 is least significant.
- Input transfer occurs on inValid & outReady.
- outReady is high only in IDLE, LOAD_KEY, LOAD_TWEAK and LOAD_BLOCK.
- Word counter width: 5 bits; resets to 0 on every state change.

State transitions:
- IDLE, first word accepted:
  - If inReuseKey & keyValid: word goes to block[0], next state LOAD_BLOCK.
  - Else: word goes to key[0], next state LOAD_KEY.
  - inReuseKey with keyValid = 0 sets outError and proceeds as a full frame.
- LOAD_KEY: after word NK-1 → LOAD_TWEAK.
- LOAD_TWEAK: after word NT-1 → LOAD_BLOCK.
- LOAD_BLOCK: after word NB-1:
  - Full frame → WR_KEY.
  - Reuse frame → WR_BLOCK.
- WR_KEY: outKeyWr = 1 for exactly one cycle; set keyValid → WR_TWEAK.
- WR_TWEAK: outTweakWr = 1 for one cycle → WR_BLOCK.
- WR_BLOCK: outBlockWr = 1 for one cycle; load timeout counter → WAIT_HI.
- WAIT_HI:
  - inCoreBusy = 1 → WAIT_LO.
  - Counter reaches BUSY_TIMEOUT → set outError, → IDLE. No output words are produced.
- WAIT_LO: inCoreBusy = 0 → CAPTURE.
- CAPTURE: register inCoreBlock into the output shift register (one cycle after busy falls) → UNLOAD.
- UNLOAD:
  - outValid = 1; outData = shift word 0.
  - On inValid-independent transfer (outValid & inReady): shift right by DATA_W.
  - After NB transfers → IDLE.
  - outData and outValid must stay stable while inReady = 0.
- Key, tweak and block registers change only in LOAD states. Never modified between WR_KEY and the end of UNLOAD.
- Minimum frame-to-first-output latency: NK+NT+NB accepts + 3 strobe cycles + core run + 2.

Test Plan:
- Full frame, DATA_W = 32: key words 0x00..0x0F, tweak 0x10..0x13, block 0x20..0x2F, inValid held high.
  - Required: outKey[31:0] = 0x00, outTweak[127:96] = 0x13, outBlock[511:480] = 0x2F.
  - Strobes fire in consecutive cycles in key, tweak, block order.
- Core model holds busy for 40 cycles with result 0xA5…A5: exactly 16 output words of 0xA5A5A5A5; outIdle returns after the last transfer.
- inReady toggled 1-0-0-1 during unload: no word lost or duplicated; outData stable during stalls.
- Reuse frame after a full frame: only 16 words accepted; only outBlockWr pulses; outKey and outTweak unchanged.
- Reuse requested right after reset: outError = 1; loader consumes 36 words as a full frame.
- Core never raises busy: after 16 cycles in WAIT_HI, outError = 1 and state returns to IDLE with no outValid.
- Reset asserted during LOAD_TWEAK and during UNLOAD: all outputs go to their reset values asynchronously, and keyValid = 0.
